fpu_add_dispatch: RTL
=====================

# fpu_add_dispatch

Request-side front end for the 16-bit floating-point adder controller. It buffers tagged add/subtract requests in a small FIFO and issues them one at a time over the controller's Data_valid/Dataout_valid protocol. Each result and its exception code is returned on a ready/valid response port, with a watchdog timeout. It sits directly upstream of the adder controller and is its only caller.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries (power of 2, ≥2)
- TIMEOUT, 64: max cycles in WAIT before a timeout response

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- Req_valid  in  1  request present
- Req_ready  out  1  FIFO can accept
- Req_op1  in  16  operand A, sign/8-bit exp/7-bit mantissa
- Req_op2  in  16  operand B
- Req_mode  in  3  MODE_ADD or MODE_SUB
- Req_tag  in  4  caller tag, returned unchanged
- Resp_valid  out  1  response present
- Resp_ready  in  1  caller accepts response
- Resp_data  out  16  result
- Resp_exc  out  3  exception code
- Resp_tag  out  4  tag of this response
- Add_datain1  out  16  to controller Datain1
- Add_datain2  out  16  to controller Datain2
- Add_mode  out  3  to controller Mode
- Add_data_valid  out  1  one-cycle issue strobe
- Add_dataout  in  16  controller Dataout
- Add_dataout_valid  in  1  controller one-cycle result strobe
- Add_exc  in  3  controller Exc, valid with Add_dataout_valid
- Err_late  out  1  sticky: result strobe seen outside WAIT
- Count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: on Req_valid && Req_ready, {op1, op2, mode, tag} enters the FIFO. Req_ready = (Count < DEPTH).
- Push at full is impossible by construction. Pop at empty never occurs; pops happen only from IDLE with Count ≠ 0.
- Simultaneous push and pop: Count unchanged. No bypass; a pushed entry is poppable the next cycle at the earliest.
- SUB: Add_datain2 = {~op2[15], op2[14:0]}. Add_mode is always driven with MODE_ADD.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: if Count ≠ 0, pop the head into the op registers and go to ISSUE.
  - ISSUE: Add_data_valid = 1 for exactly this cycle. Operands are stable from ISSUE through WAIT. Clear the timer and go to WAIT.
  - WAIT: on Add_dataout_valid, capture Add_dataout→Resp_data and Add_exc→Resp_exc, then go to RESP. Otherwise increment the timer. When timer == TIMEOUT−1 with no strobe, set Resp_data = 0 and Resp_exc = EXC_TIMEOUT, then go to RESP.
  - RESP: Resp_valid = 1. Data, exc and tag are held stable until Resp_ready; then go to IDLE.
- A strobe arriving in the same cycle as the timeout terminal count wins: the real result is captured.
- Add_dataout_valid in IDLE, ISSUE or RESP is ignored and sets Err_late. Only RST clears Err_late.
- The controller has no backpressure. Exactly one operation is outstanding, so a result strobe is never dropped while in WAIT.
- Reset mid-operation: FIFO emptied, FSM to IDLE. A controller result arriving afterwards sets Err_late and is discarded.

## Timing
- All outputs are registered. Reset values:
  - Req_ready = 1
  - Resp_valid = 0, Add_data_valid = 0, Err_late = 0, Count = 0
  - Resp_data, Resp_exc, Resp_tag, Add_datain1, Add_datain2, Add_mode = 0
- Request accepted at edge N into an empty, idle block:
  - pop at edge N+1
  - Add_data_valid high during cycle N+2 (after edge N+2)
- Controller strobe sampled at edge M gives Resp_valid high after edge M+1.
- Back-to-back: the next ISSUE is no earlier than 2 cycles after the response handshake edge (RESP→IDLE→ISSUE).
- Timeout response asserts TIMEOUT+1 cycles after the ISSUE cycle.

## Structure
- Shared package fpu_pkg holds:
  - dispatch_state_e {IDLE, ISSUE, WAIT, RESP}
  - MODE_ADD = 3'b000, MODE_SUB = 3'b001
  - EXC_NONE = 3'b000, EXC_UNDER = 3'b001, EXC_OVER = 3'b010, EXC_TIMEOUT = 3'b111
- One sub-module, fpu_req_fifo: parameterised synchronous FIFO with 39-bit entries and push/pop/count. The FSM, sign flip and timer stay in the top.

## Test plan
- Single add: 0x3F80 + 0x4000, tag 5; controller model returns 0x4040, exc 0 → one Add_data_valid pulse carrying 0x3F80/0x4000, then Resp 0x4040/0/tag 5.
- SUB: op1 0x4040, op2 0x3F80, MODE_SUB → Add_datain2 = 0xBF80, Add_mode = 0; response data passed through unchanged.
- FIFO full/backpressure: DEPTH=4, hold Resp_ready = 0, push 6 requests → Req_ready drops after 4 accepted (plus 1 popped); responses come out in tag order with no loss.
- Timeout: TIMEOUT=8, controller silent → Resp_data 0, Resp_exc 3'b111 exactly 9 cycles after ISSUE; a later strobe sets Err_late.
- Boundary: strobe coincides with timer == TIMEOUT−1 → real result returned, Err_late stays 0.
- Reset mid-WAIT with 3 entries queued → Count 0, Resp_valid 0, Add_data_valid 0 on the next cycle; no spurious response afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and encodings for the FP16 adder request front end.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dispatch_state_e;

    localparam logic [2:0] MODE_ADD    = 3'b000;
    localparam logic [2:0] MODE_SUB    = 3'b001;

    localparam logic [2:0] EXC_NONE    = 3'b000;
    localparam logic [2:0] EXC_UNDER   = 3'b001;
    localparam logic [2:0] EXC_OVER    = 3'b010;
    localparam logic [2:0] EXC_TIMEOUT = 3'b111;

    localparam int REQ_W = 39;

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [2:0]  mode;
        logic [3:0]  tag;
    } req_entry_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// Synchronous request FIFO with registered occupancy and ready flag.
module fpu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 39
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ready_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ready_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ready_q <= (count_d < CW'(DEPTH));
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/fpu_add_dispatch.sv
// Issues queued FP16 add/sub requests one at a time to the adder controller
// and returns each result on a ready/valid port, with a watchdog timeout.
//
// state | meaning
// IDLE  | waiting for a queued request; pops the head when one exists
// ISSUE | operands loaded; raises the one-cycle issue strobe, clears timer
// WAIT  | waiting for the controller result strobe or the timeout
// RESP  | response presented until the caller accepts it
module fpu_add_dispatch
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Req_valid,
    output logic                   Req_ready,
    input  logic [15:0]            Req_op1,
    input  logic [15:0]            Req_op2,
    input  logic [2:0]             Req_mode,
    input  logic [3:0]             Req_tag,
    output logic                   Resp_valid,
    input  logic                   Resp_ready,
    output logic [15:0]            Resp_data,
    output logic [2:0]             Resp_exc,
    output logic [3:0]             Resp_tag,
    output logic [15:0]            Add_datain1,
    output logic [15:0]            Add_datain2,
    output logic [2:0]             Add_mode,
    output logic                   Add_data_valid,
    input  logic [15:0]            Add_dataout,
    input  logic                   Add_dataout_valid,
    input  logic [2:0]             Add_exc,
    output logic                   Err_late,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int              TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

    dispatch_state_e state_q, state_d;
    logic [15:0]     datain1_q, datain1_d;
    logic [15:0]     datain2_q, datain2_d;
    logic [3:0]      op_tag_q, op_tag_d;
    logic            data_valid_q, data_valid_d;
    logic            resp_valid_q, resp_valid_d;
    logic [15:0]     resp_data_q, resp_data_d;
    logic [2:0]      resp_exc_q, resp_exc_d;
    logic [3:0]      resp_tag_q, resp_tag_d;
    logic            err_late_q, err_late_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic                   push;
    logic                   pop;
    logic [REQ_W-1:0]       fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_ready;
    req_entry_t             head;

    assign push = Req_valid && fifo_ready;
    assign head = req_entry_t'(fifo_rdata);

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .wdata_i ({Req_op1, Req_op2, Req_mode, Req_tag}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .ready_o (fifo_ready)
    );

    always_comb begin
        state_d      = state_q;
        datain1_d    = datain1_q;
        datain2_d    = datain2_q;
        op_tag_d     = op_tag_q;
        data_valid_d = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_exc_d   = resp_exc_q;
        resp_tag_d   = resp_tag_q;
        timer_d      = timer_q;
        pop          = 1'b0;
        err_late_d   = err_late_q | (Add_dataout_valid && (state_q != WAIT));

        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    datain1_d = head.op1;
                    // Subtraction is an add with operand B's sign inverted.
                    datain2_d = (head.mode == MODE_SUB) ? {~head.op2[15], head.op2[14:0]}
                                                        : head.op2;
                    op_tag_d  = head.tag;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                data_valid_d = 1'b1;
                timer_d      = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                // A real result takes priority over a coincident timeout.
                if (Add_dataout_valid) begin
                    resp_data_d = Add_dataout;
                    resp_exc_d  = Add_exc;
                    resp_tag_d  = op_tag_q;
                    state_d     = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    resp_data_d = '0;
                    resp_exc_d  = EXC_TIMEOUT;
                    resp_tag_d  = op_tag_q;
                    state_d     = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_valid_q && Resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            datain1_q    <= '0;
            datain2_q    <= '0;
            op_tag_q     <= '0;
            data_valid_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_exc_q   <= '0;
            resp_tag_q   <= '0;
            err_late_q   <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            datain1_q    <= datain1_d;
            datain2_q    <= datain2_d;
            op_tag_q     <= op_tag_d;
            data_valid_q <= data_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_exc_q   <= resp_exc_d;
            resp_tag_q   <= resp_tag_d;
            err_late_q   <= err_late_d;
            timer_q      <= timer_d;
        end
    end

    assign Req_ready      = fifo_ready;
    assign Count          = fifo_count;
    assign Resp_valid     = resp_valid_q;
    assign Resp_data      = resp_data_q;
    assign Resp_exc       = resp_exc_q;
    assign Resp_tag       = resp_tag_q;
    assign Add_datain1    = datain1_q;
    assign Add_datain2    = datain2_q;
    assign Add_mode       = MODE_ADD;
    assign Add_data_valid = data_valid_q;
    assign Err_late       = err_late_q;

endmodule
